// File: rtl/dmem_responder.sv
// Word-addressed data memory with active-low byte enables, write-first read merge and a post-reset zero sweep.
// Latency: read data (and par_err) registered one clk edge after the request; the sweep takes DEPTH edges.
// Backpressure: none; requests are dropped while ready=0. `define DMEM_PARITY_EN adds per-byte even parity.
module dmem_responder #(
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 16384,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_Memread,
    input  logic              MEM_Memwrite,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] DMaddr,
    input  logic [31:0]       datatoDM,
    output logic [31:0]       DMdata,
    output logic              ready,
    output logic              par_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR    = 2'd0,
        S_DONE_RST = 2'd1,
        S_IDLE     = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;
    logic [31:0]      r_dmdata;
    logic             r_ready;
    logic [31:0]      r_mem [DEPTH];

    logic [IDX_W-1:0] w_idx;
    logic             w_idle;
    logic             w_rd;
    logic             w_wr;
    logic [3:0]       w_byte_we;
    logic [31:0]      w_old;
    logic [31:0]      w_merged;

    // Upper address bits are deliberately ignored so addresses wrap modulo DEPTH.
    if (ADDR_W > IDX_W) begin : g_addr_wrap
        logic w_unused_addr;
        assign w_unused_addr = ^DMaddr[ADDR_W-1:IDX_W];
    end

    assign w_idx     = DMaddr[IDX_W-1:0];
    assign w_idle    = (r_state == S_IDLE);
    assign w_rd      = w_idle & MEM_Memread;
    assign w_wr      = w_idle & MEM_Memwrite;
    assign w_byte_we = {4{w_wr}} & ~wen;
    assign w_old     = r_mem[w_idx];

    // Write-first: a read colliding with a write returns the post-write word.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < 4; i++) begin
            if (w_byte_we[i]) w_merged[8*i +: 8] = datatoDM[8*i +: 8];
        end
    end

    // Storage: the sweep owns the array while clearing, otherwise byte-masked writes.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_we[i]) r_mem[w_idx][8*i +: 8] <= datatoDM[8*i +: 8];
            end
        end
    end

    // Control FSM: sweep (or one-cycle skip), then serve reads forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_DONE_RST;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_dmdata <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE_RST: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                S_IDLE: begin
                    if (w_rd) r_dmdata <= w_merged;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] r_par_mem [DEPTH];
    logic       r_par_err;
    logic [3:0] w_par_new;
    logic [3:0] w_par_merged;
    logic [3:0] w_par_calc;

    // Even parity per byte: the stored bit equals the XOR of the byte.
    always_comb begin
        w_par_merged = r_par_mem[w_idx];
        for (int i = 0; i < 4; i++) begin
            w_par_new[i]  = ^datatoDM[8*i +: 8];
            w_par_calc[i] = ^w_merged[8*i +: 8];
            if (w_byte_we[i]) w_par_merged[i] = w_par_new[i];
        end
    end

    // Parity storage tracks the data array; only written bytes refresh their bit.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_par_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_we[i]) r_par_mem[w_idx][i] <= w_par_new[i];
            end
        end
    end

    // Parity check result updates alongside DMdata on every honoured read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_rd) begin
            r_par_err <= |(w_par_calc ^ w_par_merged);
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign DMdata = r_dmdata;
    assign ready  = r_ready;

endmodule
